spi_reg_ctrl: RTL and testbench

//  Command sequencer directly upstream of spi_master. Queues register write/read requests,

---
 rtl/spi_pkg.sv | 30 +++
 rtl/spi_cmd_fifo.sv | 62 ++++++
 rtl/spi_reg_ctrl.sv | 143 ++++++++++++++
 tb/tb_spi_reg_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register command sequencer: FSM encoding,
// frame field positions, legal spi_master mode values and the frame packer.
package spi_pkg;

  typedef enum logic [4:0] {
    ST_IDLE = 5'b00001,
    ST_LOAD = 5'b00010,
    ST_XFER = 5'b00100,
    ST_RESP = 5'b01000,
    ST_GAP  = 5'b10000
  } state_e;

  localparam int FRAME_W  = 16;
  localparam int RW_BIT   = 15;
  localparam int ADDR_MSB = 14;
  localparam int ADDR_LSB = 8;
  localparam int DATA_MSB = 7;

  localparam logic [1:0] SPI_MODE1 = 2'd1;
  localparam logic [1:0] SPI_MODE3 = 2'd3;

  // Reads carry no payload on MOSI, so their data byte is forced to zero.
  function automatic logic [FRAME_W-1:0] pack_frame(input logic [FRAME_W-1:0] cmd);
    logic [FRAME_W-1:0] f;
    f = cmd;
    if (cmd[RW_BIT]) f[DATA_MSB:0] = '0;
    return f;
  endfunction

endpackage

// File: rtl/spi_cmd_fifo.sv
// Synchronous command queue holding {rw, addr, wdata} entries; power-of-two
// depth so the pointers wrap naturally.
module spi_cmd_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push, pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/spi_reg_ctrl.sv
// Register-access sequencer in front of spi_master: queues commands, issues one
// 16-bit frame per command with timeout and inter-frame gap, returns a response.
module spi_reg_ctrl
  import spi_pkg::*;
#(
  parameter logic [1:0]  SPI_MODE   = SPI_MODE3,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] TIMEOUT    = 16'd4000,
  parameter logic [7:0]  GAP_CYC    = 8'd4
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rw,
  input  logic [6:0]  cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic        rsp_rw,
  output logic [6:0]  rsp_addr,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_timeout,
  output logic        busy,
  output logic        spi_en,
  output logic [1:0]  spi_mode,
  output logic [15:0] spi_sdata,
  input  logic [15:0] spi_rdata,
  input  logic        spi_done
);

  state_e               state_q, state_d;
  logic [FRAME_W-1:0]   frame_q, frame_d;
  logic [7:0]           rdata_q, rdata_d;
  logic                 tmo_flag_q, tmo_flag_d;
  logic                 spi_en_q, spi_en_d;
  logic [15:0]          tmo_cnt_q, tmo_cnt_d;
  logic [7:0]           gap_cnt_q, gap_cnt_d;

  logic                 fifo_rd, fifo_full, fifo_empty;
  logic [FRAME_W-1:0]   fifo_rd_data;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                 unused_rdata_hi;

  spi_cmd_fifo #(
    .WIDTH (FRAME_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (sys_clk),
    .rst_n   (rst_n),
    .wr_en   (cmd_valid),
    .wr_data ({cmd_rw, cmd_addr, cmd_wdata}),
    .rd_en   (fifo_rd),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign cmd_ready       = !fifo_full;
  assign busy            = (state_q != ST_IDLE) || (fifo_count != '0);
  assign spi_en          = spi_en_q;
  assign spi_mode        = SPI_MODE;
  assign spi_sdata       = frame_q;
  assign rsp_valid       = (state_q == ST_RESP);
  assign rsp_rw          = frame_q[RW_BIT];
  assign rsp_addr        = frame_q[ADDR_MSB:ADDR_LSB];
  assign rsp_rdata       = rdata_q;
  assign rsp_timeout     = tmo_flag_q;
  assign unused_rdata_hi = ^spi_rdata[15:8];

  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    rdata_d    = rdata_q;
    tmo_flag_d = tmo_flag_q;
    spi_en_d   = spi_en_q;
    tmo_cnt_d  = tmo_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    fifo_rd    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_rd = 1'b1;
          frame_d = pack_frame(fifo_rd_data);
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        spi_en_d  = 1'b1;
        tmo_cnt_d = '0;
        state_d   = ST_XFER;
      end
      ST_XFER: begin
        tmo_cnt_d = tmo_cnt_q + 16'd1;
        // A done arriving on the last allowed cycle still wins over the timeout.
        if (spi_done) begin
          rdata_d    = spi_rdata[7:0];
          tmo_flag_d = 1'b0;
          spi_en_d   = 1'b0;
          state_d    = ST_RESP;
        end else if (tmo_cnt_q == TIMEOUT - 16'd1) begin
          rdata_d    = '0;
          tmo_flag_d = 1'b1;
          spi_en_d   = 1'b0;
          state_d    = ST_RESP;
        end
      end
      ST_RESP: begin
        gap_cnt_d = '0;
        state_d   = ST_GAP;
      end
      ST_GAP: begin
        gap_cnt_d = gap_cnt_q + 8'd1;
        if (({1'b0, gap_cnt_q} + 9'd1) >= {1'b0, GAP_CYC}) state_d = ST_IDLE;
      end
      default: begin
        spi_en_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      frame_q    <= '0;
      rdata_q    <= '0;
      tmo_flag_q <= 1'b0;
      spi_en_q   <= 1'b0;
      tmo_cnt_q  <= '0;
      gap_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      rdata_q    <= rdata_d;
      tmo_flag_q <= tmo_flag_d;
      spi_en_q   <= spi_en_d;
      tmo_cnt_q  <= tmo_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Bench for spi_reg_ctrl with a behavioural spi_master/slave register model
// and a response/frame scoreboard.
module tb_spi_reg_ctrl;

  localparam logic [15:0] TIMEOUT = 16'd4000;
  localparam int          GAP_CYC = 4;
  localparam int          SLV_LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_rw;
  logic [6:0]  cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid, rsp_rw, rsp_timeout, busy, spi_en, spi_done;
  logic [6:0]  rsp_addr;
  logic [7:0]  rsp_rdata;
  logic [1:0]  spi_mode;
  logic [15:0] spi_sdata, spi_rdata;

  always #10 clk = ~clk;

  spi_reg_ctrl #(
    .SPI_MODE   (2'd3),
    .FIFO_DEPTH (4),
    .TIMEOUT    (TIMEOUT),
    .GAP_CYC    (8'(GAP_CYC))
  ) dut (
    .sys_clk     (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_rw      (cmd_rw),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rw      (rsp_rw),
    .rsp_addr    (rsp_addr),
    .rsp_rdata   (rsp_rdata),
    .rsp_timeout (rsp_timeout),
    .busy        (busy),
    .spi_en      (spi_en),
    .spi_mode    (spi_mode),
    .spi_sdata   (spi_sdata),
    .spi_rdata   (spi_rdata),
    .spi_done    (spi_done)
  );

  typedef struct packed {
    logic       rw;
    logic [6:0] addr;
    logic [7:0] rdata;
    logic       tmo;
  } rsp_t;

  typedef struct {
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic [15:0] exp_frame;
    logic [7:0] exp_rdata;
  } vec_t;

  rsp_t        rsp_q[$];
  logic [15:0] frame_q[$];
  logic [7:0]  slv_mem [128];
  logic [7:0]  mdl_mem [128];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          rsp_cnt  = 0;
  int          last_plen = 0;
  bit          slave_mute = 1'b0;
  bit          force_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Slave: answers each frame SLV_LAT cycles into spi_en with old register contents.
  initial begin
    int cnt;
    cnt = 0;
    spi_done = 1'b0;
    spi_rdata = 16'h0;
    forever begin
      @(negedge clk);
      spi_done = force_done;
      if (!rst_n || !spi_en || slave_mute) cnt = 0;
      else begin
        cnt++;
        if (cnt == SLV_LAT) begin
          spi_done  = 1'b1;
          spi_rdata = {8'hEE, slv_mem[spi_sdata[14:8]]};
          if (!spi_sdata[15]) slv_mem[spi_sdata[14:8]] = spi_sdata[7:0];
          cnt = 0;
        end
      end
    end
  end

  // Monitor: response scoreboard, frame contents, stability, pulse/gap lengths.
  initial begin
    bit          en_prev, stable, have_prev;
    logic [15:0] held;
    int          plen, glen;
    rsp_t        e;
    en_prev = 0; stable = 0; have_prev = 0; held = '0; plen = 0; glen = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        en_prev = 0; have_prev = 0; plen = 0; glen = 0;
      end else begin
        if (rsp_valid) begin
          rsp_cnt++;
          check("rsp_expected", 32'(rsp_q.size() != 0), 1);
          if (rsp_q.size() != 0) begin
            e = rsp_q.pop_front();
            check("rsp_rw", rsp_rw, e.rw);
            check("rsp_addr", rsp_addr, e.addr);
            check("rsp_rdata", rsp_rdata, e.rdata);
            check("rsp_timeout", rsp_timeout, e.tmo);
          end
        end
        if (spi_en && !en_prev) begin
          if (have_prev) check("gap_len_ok", 32'(glen >= GAP_CYC), 1);
          check("frame_expected", 32'(frame_q.size() != 0), 1);
          if (frame_q.size() != 0) check("spi_sdata", spi_sdata, frame_q.pop_front());
          held = spi_sdata; stable = 1; plen = 0;
        end
        if (spi_en) begin
          plen++;
          if (spi_sdata !== held) stable = 0;
        end
        if (!spi_en && en_prev) begin
          check("sdata_stable", 32'(stable), 1);
          last_plen = plen; have_prev = 1; glen = 0;
        end
        if (!spi_en) glen++;
        en_prev = spi_en;
      end
    end
  end

  task automatic push_cmd(input logic rw, input logic [6:0] a, input logic [7:0] d,
                          input logic [15:0] ef, input logic [7:0] er, input logic et,
                          output bit acc);
    rsp_t r;
    cmd_valid = 1'b1; cmd_rw = rw; cmd_addr = a; cmd_wdata = d;
    acc = cmd_ready;
    @(posedge clk);
    if (acc) begin
      r.rw = rw; r.addr = a; r.rdata = er; r.tmo = et;
      rsp_q.push_back(r);
      frame_q.push_back(ef);
      if (!rw && !et) mdl_mem[a] = d;
    end
    @(negedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic model_push(input logic rw, input logic [6:0] a, input logic [7:0] d,
                            input logic et, output bit acc);
    logic [15:0] ef;
    logic [7:0]  er;
    ef = {rw, a, (rw ? 8'h00 : d)};
    er = et ? 8'h00 : mdl_mem[a];
    push_cmd(rw, a, d, ef, er, et, acc);
  endtask

  task automatic wait_rsp(input int target, input int budget, input string name);
    int k;
    k = 0;
    while (rsp_cnt < target && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    check(name, 32'(rsp_cnt >= target), 1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    bit   acc, found;
    int   base, k;
    vecs[0] = '{1'b0, 7'h12, 8'hA5, 16'h12A5, 8'h48};
    vecs[1] = '{1'b1, 7'h05, 8'h77, 16'h8500, 8'h3C};
    vecs[2] = '{1'b1, 7'h12, 8'h00, 16'h9200, 8'hA5};
    vecs[3] = '{1'b0, 7'h7F, 8'hFF, 16'h7FFF, 8'h25};
    vecs[4] = '{1'b1, 7'h7F, 8'hAA, 16'hFF00, 8'hFF};
    vecs[5] = '{1'b0, 7'h00, 8'h00, 16'h0000, 8'h5A};
    vecs[6] = '{1'b1, 7'h00, 8'hC3, 16'h8000, 8'h00};
    for (int i = 0; i < 128; i++) begin
      slv_mem[i] = 8'(i) ^ 8'h5A;
      mdl_mem[i] = 8'(i) ^ 8'h5A;
    end
    slv_mem[5] = 8'h3C; mdl_mem[5] = 8'h3C;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_spi_en", spi_en, 0);
    check("rst_spi_mode", spi_mode, 2'd3);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_spi_sdata", spi_sdata, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    rst_n = 1'b1;
    @(negedge clk); #1;

    // Latency from an idle, empty block.
    model_push(1'b0, 7'h21, 8'h5A, 1'b0, acc);
    check("lat_accept", acc, 1);
    check("lat_pop_spi_en", spi_en, 0);
    check("lat_busy", busy, 1);
    @(negedge clk); #1;
    check("lat_load_spi_en", spi_en, 0);
    check("lat_load_sdata", spi_sdata, 16'h215A);
    @(negedge clk); #1;
    check("lat_xfer_spi_en", spi_en, 1);
    k = 0;
    while (!spi_done && k < 50) begin @(negedge clk); #1; k++; end
    check("lat_done_seen", spi_done, 1);
    @(negedge clk); #1;
    check("lat_rsp_after_done", rsp_valid, 1);
    check("lat_spi_en_dropped", spi_en, 0);
    @(negedge clk); #1;
    check("lat_rsp_one_cycle", rsp_valid, 0);
    wait_rsp(1, 20, "lat_rsp");

    // Table-driven single commands.
    for (int i = 0; i < 7; i++) begin
      base = rsp_cnt;
      push_cmd(vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].exp_frame,
               vecs[i].exp_rdata, 1'b0, acc);
      check("vec_accept", acc, 1);
      wait_rsp(base + 1, 100, "vec_rsp");
    end
    repeat (8) @(negedge clk);
    #1;

    // Five back-to-back pushes, then a held sixth that must wait for a free slot.
    base = rsp_cnt;
    for (int i = 0; i < 5; i++) begin
      model_push(1'(i), 7'h40 + 7'(i), 8'h11 * 8'(i), 1'b0, acc);
      check("burst_accept", acc, 1);
    end
    check("burst_ready_low", cmd_ready, 0);
    cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 7'h44; cmd_wdata = 8'h99;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk); #1;
      if (cmd_ready) found = 1;
    end
    check("held_ready_seen", found, 1);
    check("held_accept_in_load", spi_en, 0);
    model_push(1'b0, 7'h44, 8'h99, 1'b0, acc);
    check("held_accept", acc, 1);
    check("held_xfer_next", spi_en, 1);
    wait_rsp(base + 6, 400, "burst_rsp");

    // Timeout followed by a normal command.
    base = rsp_cnt;
    slave_mute = 1'b1;
    model_push(1'b0, 7'h33, 8'h11, 1'b1, acc);
    check("tmo_accept", acc, 1);
    model_push(1'b1, 7'h33, 8'h00, 1'b0, acc);
    check("tmo_next_accept", acc, 1);
    wait_rsp(base + 1, int'(TIMEOUT) + 50, "tmo_rsp");
    slave_mute = 1'b0;
    check("tmo_pulse_len", last_plen, 32'(TIMEOUT));
    wait_rsp(base + 2, 200, "tmo_next_rsp");
    repeat (8) @(negedge clk);

    // spi_done while idle is ignored.
    base = rsp_cnt;
    @(posedge clk); #2 force_done = 1'b1;
    @(posedge clk); #2 force_done = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    check("stray_done_no_rsp", rsp_cnt, base);
    check("stray_done_idle", busy, 0);

    // Asynchronous reset mid-transfer with commands queued.
    slave_mute = 1'b1;
    model_push(1'b0, 7'h50, 8'h01, 1'b0, acc);
    model_push(1'b0, 7'h51, 8'h02, 1'b0, acc);
    model_push(1'b1, 7'h52, 8'h00, 1'b0, acc);
    k = 0;
    while (!spi_en && k < 20) begin @(negedge clk); #1; k++; end
    check("rst_mid_in_xfer", spi_en, 1);
    #3 rst_n = 1'b0;
    #1;
    check("rst_mid_spi_en", spi_en, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_cmd_ready", cmd_ready, 1);
    check("rst_mid_rsp_valid", rsp_valid, 0);
    rsp_q.delete();
    frame_q.delete();
    slave_mute = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    base = rsp_cnt;
    repeat (40) @(negedge clk);
    #1;
    check("rst_mid_no_rsp", rsp_cnt, base);
    check("rst_mid_idle_busy", busy, 0);
    check("rst_mid_idle_en", spi_en, 0);
    check("scoreboard_drained", rsp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
